conv_pass_sequencer: RTL and testbench

- Clocked sequencer for the 3x3-filter / 5x5-mapper convolution array.
- Takes one start token and runs NUM passes. On each pass it issues a go to every unit (9 PEs, the adder, the memory) and gathers a done from every unit.
- Returns a single done token when all passes finish, or when a pass times out.
- Sits between the host/testbench start/done channel and the array's per-unit control lines.

---
 rtl/conv_ctrl_pkg.sv | 28 ++
 rtl/conv_pass_sequencer_if.sv | 30 +++
 rtl/unit_handshake_tracker.sv | 51 +++++
 rtl/conv_pass_sequencer.sv | 163 ++++++++++++++++
 tb/tb_conv_pass_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution-array control path.
// Provides the sequencer state type, the default unit count and the
// bit positions of each controlled unit inside the per-unit vectors.
package conv_ctrl_pkg;

  localparam int N_UNITS_DEF = 11;

  // Unit index map used by every per-unit control vector
  localparam int PE0_IDX = 0;
  localparam int PE1_IDX = 1;
  localparam int PE2_IDX = 2;
  localparam int PE3_IDX = 3;
  localparam int PE4_IDX = 4;
  localparam int PE5_IDX = 5;
  localparam int PE6_IDX = 6;
  localparam int PE7_IDX = 7;
  localparam int PE8_IDX = 8;
  localparam int ADD_IDX = 9;
  localparam int MEM_IDX = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/conv_pass_sequencer_if.sv
// Bundle of the sequencer's host start/done channel and the per-unit
// go/ack/done control lines.
//   master : host + array side (drives start, done_ready, unit_ack, unit_done)
//   slave  : sequencer side (drives start_ready, done token, unit_go, status)
interface conv_pass_sequencer_if #(
  parameter int N_UNITS = 11,
  parameter int PASS_W  = 4
);
  logic               start_valid;
  logic               start_ready;
  logic [PASS_W-1:0]  num_pass;
  logic [N_UNITS-1:0] unit_go;
  logic [N_UNITS-1:0] unit_ack;
  logic [N_UNITS-1:0] unit_done;
  logic               done_valid;
  logic               done_ready;
  logic               done_err;
  logic               busy;
  logic [PASS_W-1:0]  pass_idx;

  modport master (
    output start_valid, num_pass, done_ready, unit_ack, unit_done,
    input  start_ready, unit_go, done_valid, done_err, busy, pass_idx
  );

  modport slave (
    input  start_valid, num_pass, done_ready, unit_ack, unit_done,
    output start_ready, unit_go, done_valid, done_err, busy, pass_idx
  );
endinterface

// File: rtl/unit_handshake_tracker.sv
// Per-unit go/ack/done bookkeeping for one pass of the sequencer.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   i_clear       start of a new pass: both mask bits drop, go re-arms
//   i_issue_en    sequencer will be in ISSUE next cycle
//   i_capture_en  sequencer is in ISSUE or WAIT (done is recorded)
//   i_ack, i_done unit's go acceptance and completion
//   o_go          registered go request to the unit
//   o_ack_set     ack mask bit including an acceptance on this edge
//   o_done_set    done mask bit including a done on this edge
module unit_handshake_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_issue_en,
  input  logic i_capture_en,
  input  logic i_ack,
  input  logic i_done,
  output logic o_go,
  output logic o_ack_set,
  output logic o_done_set
);

  logic r_go;
  logic r_ack;
  logic r_done;

  // Merged mask values; reported before clear so the parent's pass
  // decision never depends on its own clear.
  assign o_ack_set  = r_ack  | (r_go & i_ack);
  assign o_done_set = r_done | (i_capture_en & i_done);
  assign o_go       = r_go;

  // Mask bits and go request; go falls the cycle after its acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go   <= 1'b0;
      r_ack  <= 1'b0;
      r_done <= 1'b0;
    end else if (i_clear) begin
      r_go   <= i_issue_en;
      r_ack  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_go   <= i_issue_en & ~o_ack_set;
      r_ack  <= o_ack_set;
      r_done <= o_done_set;
    end
  end

endmodule

// File: rtl/conv_pass_sequencer.sv
// Multi-pass sequencer for the 3x3-filter / 5x5-mapper convolution array.
// Accepts one start token, runs num_pass passes (0 treated as 1), each pass
// issuing go to every unit and collecting a done from every unit, then
// returns one done token (done_err = 1 when a pass exceeded TIMEOUT cycles).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         slave view of conv_pass_sequencer_if (start/done channel,
//               unit_go/unit_ack/unit_done, busy, pass_idx)
module conv_pass_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int              N_UNITS = N_UNITS_DEF,
  parameter int              PASS_W  = 4,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'hFFFF
) (
  input logic                  clk,
  input logic                  rst_n,
  conv_pass_sequencer_if.slave bus
);

  localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0]   TIME_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [PASS_W-1:0] r_np;
  logic [PASS_W-1:0] r_pass_idx;
  logic [TO_W-1:0]   r_timer;
  logic              r_done_valid;
  logic              r_done_err;

  logic [N_UNITS-1:0] w_go;
  logic [N_UNITS-1:0] w_ack_set;
  logic [N_UNITS-1:0] w_done_set;
  logic w_clear, w_issue_en, w_capture_en;
  logic w_start_xfer, w_resp_xfer, w_timeout, w_last_pass;
  logic w_ack_all, w_done_all, w_pass_ok;

  assign w_start_xfer = bus.start_valid & (r_state == IDLE);
  assign w_resp_xfer  = r_done_valid & bus.done_ready;
  assign w_timeout    = (r_timer == TIMEOUT);
  assign w_last_pass  = (r_pass_idx == (r_np - PASS_ONE));
  assign w_ack_all    = &w_ack_set;
  assign w_done_all   = &w_done_set;
  assign w_pass_ok    = (r_state == WAIT) & w_done_all;
  assign w_issue_en   = (w_state_nxt == ISSUE);
  assign w_capture_en = (r_state == ISSUE) | (r_state == WAIT);

  genvar g;
  for (g = 0; g < N_UNITS; g++) begin : g_trk
    unit_handshake_tracker u_trk (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clear      (w_clear),
      .i_issue_en   (w_issue_en),
      .i_capture_en (w_capture_en),
      .i_ack        (bus.unit_ack[g]),
      .i_done       (bus.unit_done[g]),
      .o_go         (w_go[g]),
      .o_ack_set    (w_ack_set[g]),
      .o_done_set   (w_done_set[g])
    );
  end

  // Next state; in WAIT, completion is tested before the timeout so it wins a tie
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_xfer) begin
          w_state_nxt = ISSUE;
          w_clear     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (w_timeout) begin
          w_state_nxt = RESP;
        end else if (w_ack_all) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      WAIT: begin
        if (w_done_all) begin
          if (w_last_pass) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = ISSUE;
            w_clear     = 1'b1;
          end
        end else if (w_timeout) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP: begin
        if (w_resp_xfer) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, pass counter, pass timer and the registered done token
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_np         <= PASS_ONE;
      r_pass_idx   <= {PASS_W{1'b0}};
      r_timer      <= {TO_W{1'b0}};
      r_done_valid <= 1'b0;
      r_done_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_start_xfer) begin
            r_np       <= (bus.num_pass == {PASS_W{1'b0}}) ? PASS_ONE : bus.num_pass;
            r_pass_idx <= {PASS_W{1'b0}};
            r_timer    <= {TO_W{1'b0}};
          end
        end
        ISSUE, WAIT: begin
          // On abort pass_idx is left at the failing pass for debug
          if (w_state_nxt == RESP) begin
            r_done_valid <= 1'b1;
            r_done_err   <= ~w_pass_ok;
          end else if (w_clear) begin
            r_pass_idx <= r_pass_idx + PASS_ONE;
            r_timer    <= {TO_W{1'b0}};
          end else begin
            r_timer <= r_timer + TIME_ONE;
          end
        end
        RESP: begin
          if (w_resp_xfer) begin
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
            r_pass_idx   <= {PASS_W{1'b0}};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.unit_go     = w_go;
  assign bus.done_valid  = r_done_valid;
  assign bus.done_err    = r_done_err;
  assign bus.pass_idx    = r_pass_idx;

endmodule

// File: tb/tb_conv_pass_sequencer.sv
module tb_conv_pass_sequencer;

  localparam int NU = 11;

  logic clk;
  logic rst_n;

  conv_pass_sequencer_if #(.N_UNITS(NU), .PASS_W(4)) bus ();

  conv_pass_sequencer #(
    .N_UNITS (NU),
    .PASS_W  (4),
    .TO_W    (16),
    .TIMEOUT (16'd20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [3:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_issued = 0;
  int   n_tokens = 0;

  // unit behaviour configuration
  int cfg_mode  = 1;  // 0 random, 1 fixed, 2 staggered, 3 early unit 10, 4 slow done
  int hang_pass = -1;
  int hang_unit = 0;

  int a_ack_cnt[NU];
  int a_done_cnt[NU];
  bit a_armed[NU];
  bit a_prev_go[NU];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ack_delay(input int i);
    case (cfg_mode)
      0: return $urandom_range(0, 6);
      2: return i;
      3: return (i == 10) ? 5 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int done_delay(input int i);
    case (cfg_mode)
      0: return $urandom_range(0, 6);
      1: return 4;
      2: return i + 1;
      3: return (i == 10) ? 0 : 3;
      4: return 6;
      default: return 4;
    endcase
  endfunction

  // Unit agents: react to go, ack after a delay, pulse done after a delay
  initial begin
    bus.unit_ack  = '0;
    bus.unit_done = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NU; i++) begin
        if (!rst_n) begin
          bus.unit_ack[i]  = 1'b0;
          bus.unit_done[i] = 1'b0;
          a_armed[i]       = 1'b0;
          a_prev_go[i]     = 1'b0;
        end else begin
          if (bus.unit_go[i] && !a_prev_go[i]) begin
            a_ack_cnt[i]  = ack_delay(i);
            a_done_cnt[i] = done_delay(i);
            a_armed[i]    = !(i == hang_unit && int'(bus.pass_idx) == hang_pass);
          end
          a_prev_go[i] = bus.unit_go[i];
          if (bus.unit_go[i] && a_ack_cnt[i] == 0) begin
            bus.unit_ack[i] = 1'b1;
          end else begin
            bus.unit_ack[i] = 1'b0;
            if (bus.unit_go[i]) a_ack_cnt[i]--;
          end
          if (a_armed[i] && a_done_cnt[i] == 0) begin
            bus.unit_done[i] = 1'b1;
            a_armed[i]       = 1'b0;
          end else begin
            bus.unit_done[i] = 1'b0;
            if (a_armed[i]) a_done_cnt[i]--;
          end
        end
      end
    end
  end

  // Monitor: protocol checks every cycle, scoreboard pop on each done transfer
  initial begin
    logic [NU-1:0] p_go;
    logic p_dv, p_err, p_busy, p_sr;
    logic [3:0] p_idx;
    int go_rises;
    exp_t e;
    p_go = '0; p_dv = 1'b0; p_err = 1'b0; p_busy = 1'b0; p_sr = 1'b0; p_idx = '0;
    go_rises = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        p_go = '0; p_dv = 1'b0; p_err = 1'b0; p_busy = 1'b0; p_sr = 1'b0; p_idx = '0;
      end else begin
        if (p_sr && bus.start_valid) go_rises = 0;
        if (bus.unit_go[0] && !p_go[0]) go_rises++;
        for (int i = 0; i < NU; i++)
          if (p_go[i] && bus.unit_ack[i]) chk($sformatf("go_drop[%0d]", i), 32'(bus.unit_go[i]), 32'd0);
        chk("ready_vs_busy", 32'(bus.start_ready), 32'(!bus.busy));
        if (p_dv && !bus.done_ready) begin
          chk("resp_hold_valid", 32'(bus.done_valid), 32'd1);
          chk("resp_hold_err", 32'(bus.done_err), 32'(p_err));
        end
        if (bus.done_valid) chk("go_in_resp", 32'(bus.unit_go), 32'd0);
        if (bus.busy && p_busy && !bus.done_valid && bus.pass_idx != p_idx)
          chk("pass_step", 32'(bus.pass_idx), 32'(p_idx + 4'd1));
        if (p_dv && bus.done_ready) begin
          n_tokens++;
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_err", 32'(p_err), 32'(e.err));
            chk("done_pass_idx", 32'(p_idx), 32'(e.idx));
            chk("passes_run", 32'(go_rises), 32'(e.idx) + 32'd1);
            chk("idle_after_done", 32'(bus.busy), 32'd0);
          end
        end
        p_go = bus.unit_go; p_dv = bus.done_valid; p_err = bus.done_err;
        p_busy = bus.busy; p_sr = bus.start_ready; p_idx = bus.pass_idx;
      end
    end
  end

  task automatic start_run(input logic [3:0] np, input int hp, input int hu, input int md);
    int b;
    exp_t e;
    int eff;
    b = 0;
    while (!bus.start_ready && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("start_ready_wait", 32'(bus.start_ready), 32'd1);
    cfg_mode = md; hang_pass = hp; hang_unit = hu;
    eff = (np == 4'd0) ? 1 : int'(np);
    if (hp >= 0 && hp < eff) begin
      e.err = 1'b1; e.idx = 4'(hp);
    end else begin
      e.err = 1'b0; e.idx = 4'(eff - 1);
    end
    sb.push_back(e);
    n_issued++;
    bus.num_pass    = np;
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.num_pass    = 4'($urandom);
  endtask

  task automatic finish_run(input int hold);
    int b;
    b = 0;
    while (!bus.done_valid && b < 1000) begin
      @(negedge clk);
      b++;
    end
    chk("done_valid_wait", 32'(bus.done_valid), 32'd1);
    repeat (hold) @(negedge clk);
    bus.done_ready = 1'b1;
    @(negedge clk);
    bus.done_ready = 1'b0;
  endtask

  initial begin
    int b;
    rst_n = 1'b0;
    bus.start_valid = 1'b0;
    bus.num_pass    = 4'd0;
    bus.done_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("rst_unit_go", 32'(bus.unit_go), 32'd0);
    chk("rst_pass_idx", 32'(bus.pass_idx), 32'd0);

    // single pass, immediate acks, done after 4 cycles
    start_run(4'd1, -1, 0, 1);
    finish_run(0);
    // three passes, staggered acks and dones
    start_run(4'd3, -1, 0, 2);
    finish_run(1);
    // unit 10 finishes before it acks
    start_run(4'd2, -1, 0, 3);
    finish_run(0);
    // unit 4 never finishes: timeout with pass_idx held
    start_run(4'd1, 0, 4, 1);
    finish_run(2);
    // timeout in a later pass
    start_run(4'd3, 2, 7, 0);
    finish_run(0);

    // done_ready held off while a new start waits
    start_run(4'd2, -1, 0, 0);
    sb.push_back('{err: 1'b0, idx: 4'd0});
    n_issued++;
    bus.num_pass    = 4'd1;
    bus.start_valid = 1'b1;
    finish_run(10);
    b = 0;
    while (!bus.busy && b < 20) begin
      @(negedge clk);
      b++;
    end
    chk("queued_start_taken", 32'(bus.busy), 32'd1);
    bus.start_valid = 1'b0;
    finish_run(0);

    // reset during WAIT of pass 1
    start_run(4'd3, -1, 0, 4);
    b = 0;
    while (!(bus.pass_idx == 4'd1 && bus.unit_go == '0 && bus.busy) && b < 200) begin
      @(negedge clk);
      b++;
    end
    chk("reached_wait_p1", 32'(bus.pass_idx), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("arst_done_err", 32'(bus.done_err), 32'd0);
    chk("arst_unit_go", 32'(bus.unit_go), 32'd0);
    chk("arst_pass_idx", 32'(bus.pass_idx), 32'd0);
    void'(sb.pop_back());
    n_issued--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(4'd0, -1, 0, 1);
    finish_run(1);

    // randomized runs
    for (int r = 0; r < 30; r++) begin
      int hp;
      hp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      start_run(4'($urandom_range(0, 5)), hp, int'($urandom_range(0, NU - 1)), 0);
      finish_run(int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("token_count", 32'(n_tokens), 32'(n_issued));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end

endmodule
